mem_kxn: RTL

- Parametrised single-port synchronous RAM that generalises the 1-bit x 1024 display memory to W bits x DEPTH words.
- Adds a per-bit write mask, a selectable read-during-write mode, an optional output register stage, a read-valid strobe, and a self-clearing sweep engine.
- Used for survivor/traceback storage and display buffers in the Viterbi decoder, where a deterministic post-reset memory content is required.

---
 rtl/mem_kxn.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_kxn.sv
// rtl/mem_kxn.sv - W x DEPTH single-port RAM with write mask, read-during-write mode, optional output register and clear sweep
module mem_kxn #(
    parameter int              W        = 1,
    parameter int              DEPTH    = 1024,
    parameter int              AW       = $clog2(DEPTH),
    parameter int              OUT_REG  = 0,
    parameter int              RDW_MODE = 0,
    parameter logic [W-1:0]    INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    input  logic          wr,
    input  logic          rd,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  d_i,
    input  logic [W-1:0]  wmask,
    output logic [W-1:0]  d_o,
    output logic          d_o_vld
);

    localparam logic [AW:0]   LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr, w_ptr_nxt;
    logic [W-1:0]  r_mem [0:DEPTH-1];
    logic [W-1:0]  r_d_o;
    logic          r_vld;

    logic          w_idle_acc;
    logic          w_in_range;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [W-1:0]  w_old;
    logic [W-1:0]  w_merged;
    logic [W-1:0]  w_rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_CLEAR: begin
                if (clr) begin
                    w_ptr_nxt = '0;
                end else if (r_ptr == LP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + AW'(1);
                end
            end
            default: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
        endcase
    end

    assign busy       = (r_state == S_CLEAR);
    // clr wins over any same-cycle access
    assign w_idle_acc = (r_state == S_IDLE) && !clr;
    assign w_in_range = ({1'b0, addr} < LP_DEPTH);
    assign w_wr_en    = w_idle_acc && wr && w_in_range;
    assign w_rd_en    = w_idle_acc && rd;
    assign w_old      = w_in_range ? r_mem[addr] : '0;
    assign w_merged   = (w_old & ~wmask) | (d_i & wmask);

    always_comb begin
        w_rd_word = w_old;
        if (!w_in_range)
            w_rd_word = '0;
        else if ((RDW_MODE != 0) && wr)
            w_rd_word = w_merged;
    end

    // Array is deliberately left out of reset; the sweep gives it defined contents.
    always_ff @(posedge clk) begin
        if (busy)
            r_mem[r_ptr] <= INIT_VAL;
        else if (w_wr_en)
            r_mem[addr] <= w_merged;
    end

    generate
        if (OUT_REG == 0) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d_o <= '0;
                    r_vld <= 1'b0;
                end else begin
                    r_vld <= w_rd_en;
                    if (w_rd_en)
                        r_d_o <= w_rd_word;
                end
            end
        end else begin : g_lat2
            logic [W-1:0] r_p_data;
            logic         r_p_vld;
            logic         w_p_fire;

            // A result still in the pipe when a sweep starts is discarded.
            assign w_p_fire = r_p_vld && w_idle_acc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_p_data <= '0;
                    r_p_vld  <= 1'b0;
                    r_d_o    <= '0;
                    r_vld    <= 1'b0;
                end else begin
                    r_p_vld <= w_rd_en;
                    if (w_rd_en)
                        r_p_data <= w_rd_word;
                    r_vld <= w_p_fire;
                    if (w_p_fire)
                        r_d_o <= r_p_data;
                end
            end
        end
    endgenerate

    assign d_o     = r_d_o;
    assign d_o_vld = r_vld;

endmodule
